// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
// Signed MULT/DIV support is controlled by the MULDIV_SIGNED_EN macro.
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MULT  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One shift-add multiply or restoring-divide iteration over a single
// WIDTH+1-bit adder; purely combinational.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] add_a;
  logic [WIDTH:0] add_b;
  logic [WIDTH:0] sum;
  logic           no_borrow;

  always_comb begin
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    add_a   = {1'b0, acc_hi};
    add_b   = {1'b0, operand};
    if (div) begin
      add_a = shifted;
      add_b = ~{1'b0, operand};
    end else if (!acc_lo[0]) begin
      add_b = '0;
    end
    sum = add_a + add_b + {{WIDTH{1'b0}}, div};
    // The remainder is below the divisor, so a set top bit of the shifted
    // remainder already guarantees the subtraction cannot borrow.
    no_borrow = shifted[WIDTH] | ~sum[WIDTH];
    if (div) begin
      nxt_hi = no_borrow ? sum[WIDTH-1:0] : shifted[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], no_borrow};
    end else begin
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/DIV sequencer returning a {hi, lo} pair.
// Macro MULDIV_SIGNED_EN enables signed MULT/DIV and the FIX state.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             phi,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_hi,
  output logic [WIDTH-1:0] resp_lo,
  output muldiv_state_t    dbg_state
);

  // Handshakes: a request transfers on the edge where req_valid & req_ready,
  // a response on the edge where resp_valid & resp_ready; flush beats both.

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t    state;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] operand;
  logic [CW-1:0]    count;
  logic             op_div;
  logic             dbz;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             div_zero;

`ifdef MULDIV_SIGNED_EN
  logic             neg_lo;
  logic             neg_hi;
  assign sa = req_op[1] & req_a[WIDTH-1];
  assign sb = req_op[1] & req_b[WIDTH-1];
`else
  logic             unused_op_hi;
  assign unused_op_hi = req_op[1];
  assign sa = 1'b0;
  assign sb = 1'b0;
`endif

  assign abs_a    = sa ? ('0 - req_a) : req_a;
  assign abs_b    = sb ? ('0 - req_b) : req_b;
  assign div_zero = req_op[0] && (req_b == '0);

  assign resp_hi   = acc_hi;
  assign resp_lo   = acc_lo;
  assign dbg_state = state;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div     (op_div),
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .operand (operand),
    .nxt_hi  (step_hi),
    .nxt_lo  (step_lo)
  );

  always_ff @(posedge phi) begin
    if (rst) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      operand    <= '0;
      count      <= '0;
      op_div     <= 1'b0;
      dbz        <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_lo     <= 1'b0;
      neg_hi     <= 1'b0;
`endif
    end else if (flush) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            state     <= S_RUN;
            req_ready <= 1'b0;
            op_div    <= req_op[0];
            dbz       <= div_zero;
            count     <= CW'(WIDTH - 1);
            operand   <= req_op[0] ? abs_b : abs_a;
            // Divide by zero preloads its fixed answer and skips iteration.
            acc_lo    <= div_zero ? '1 : (req_op[0] ? abs_a : abs_b);
            acc_hi    <= div_zero ? req_a : '0;
`ifdef MULDIV_SIGNED_EN
            neg_lo    <= sa ^ sb;
            neg_hi    <= req_op[0] ? sa : (sa ^ sb);
`endif
          end
        end
        S_RUN: begin
          if (dbz) begin
            state      <= S_DONE;
            resp_valid <= 1'b1;
          end else begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            count  <= count - CW'(1);
            if (count == '0) begin
`ifdef MULDIV_SIGNED_EN
              if (neg_lo | neg_hi) begin
                state <= S_FIX;
              end else begin
                state      <= S_DONE;
                resp_valid <= 1'b1;
              end
`else
              state      <= S_DONE;
              resp_valid <= 1'b1;
`endif
            end
          end
        end
`ifdef MULDIV_SIGNED_EN
        S_FIX: begin
          if (op_div) begin
            acc_lo <= neg_lo ? ('0 - acc_lo) : acc_lo;
            acc_hi <= neg_hi ? ('0 - acc_hi) : acc_hi;
          end else begin
            {acc_hi, acc_lo} <= '0 - {acc_hi, acc_lo};
          end
          state      <= S_DONE;
          resp_valid <= 1'b1;
        end
`endif
        S_DONE: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
